// File: rtl/engine_vco_if.sv
// Engine-sound VCO interface: LFO-side controls in, tick and waveform out.
interface engine_vco_if;
    logic       clk_3MHz_en;
    logic       engine_en;
    logic [7:0] level;
    logic       vco_tick;
    logic [7:0] out;

    modport master (
        output clk_3MHz_en, engine_en, level,
        input  vco_tick, out
    );

    modport slave (
        input  clk_3MHz_en, engine_en, level,
        output vco_tick, out
    );
endinterface

// File: rtl/engine_vco.sv
// Engine VCO: converts the LFO level into a variable-rate tick that clocks two
// load-and-count dividers whose MSBs are mixed into an 8-bit engine waveform.
module engine_vco #(
    parameter int unsigned BASE_PERIOD = 1024,
    parameter int unsigned SLOPE       = 3,
    parameter int unsigned MIN_PERIOD  = 64,
    parameter int unsigned A_LOAD      = 6,
    parameter int unsigned B_LOAD      = 5,
    parameter int unsigned AMP         = 127
) (
    input  logic         clk,
    input  logic         rst,
    engine_vco_if.slave  bus
);
    localparam logic [15:0] BASE16  = 16'(BASE_PERIOD);
    localparam logic [15:0] MIN16   = 16'(MIN_PERIOD);
    localparam logic [15:0] KNEE16  = 16'(BASE_PERIOD - MIN_PERIOD);
    localparam logic [15:0] SLOPE16 = 16'(SLOPE);
    localparam logic [3:0]  A_LD    = 4'(A_LOAD);
    localparam logic [3:0]  B_LD    = 4'(B_LOAD);
    localparam logic [7:0]  AMP8    = 8'(AMP);

    logic [15:0] prod;
    logic [15:0] period;
    logic [15:0] cnt;
    logic [3:0]  div_a;
    logic [3:0]  div_b;
    logic        fire;
    logic [7:0]  mix;

    // Clamp before subtracting so a large level*SLOPE can never wrap the period.
    always_comb begin
        prod = 16'(bus.level) * SLOPE16;
        if (prod >= KNEE16) begin
            period = MIN16;
        end else begin
            period = BASE16 - prod;
        end
    end

    always_comb begin
        fire = bus.clk_3MHz_en && (cnt == '0);
        mix  = (div_a[3] ? AMP8 : '0) + (div_b[3] ? AMP8 : '0);
    end

    always_ff @(posedge clk) begin
        if (rst || !bus.engine_en) begin
            cnt          <= '0;
            div_a        <= A_LD;
            div_b        <= B_LD;
            bus.vco_tick <= 1'b0;
            bus.out      <= '0;
        end else begin
            bus.vco_tick <= fire;
            bus.out      <= mix;
            if (bus.clk_3MHz_en) begin
                if (cnt == '0) begin
                    cnt <= period - 16'd1;
                end else begin
                    cnt <= cnt - 16'd1;
                end
            end
            if (fire) begin
                div_a <= (div_a == 4'hF) ? A_LD : div_a + 4'd1;
                div_b <= (div_b == 4'hF) ? B_LD : div_b + 4'd1;
            end
        end
    end
endmodule

// File: tb/tb_engine_vco.sv
// Bench for engine_vco: per-clock scoreboard against a tick-count model, plus
// explicit period and waveform checks; a second instance exercises the clamp.
module tb_engine_vco;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    engine_vco_if bus ();
    engine_vco_if bus4 ();

    engine_vco dut (.clk(clk), .rst(rst), .bus(bus));
    engine_vco #(.SLOPE(4)) dut4 (.clk(clk), .rst(rst), .bus(bus4));

    typedef struct {
        logic       tick;
        logic [7:0] out;
    } exp_t;

    exp_t sbq[$];
    int   errors = 0;
    int   checks = 0;
    int   m_rem  = 0;
    int   m_n    = 0;
    int   strobes = 0;
    bit   dut4_done = 0;

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0d expected=%0d", tag, got, exp);
        end
    endtask

    function automatic int exp_period(input int lvl, input int slope);
        int p;
        p = lvl * slope;
        return (p >= 1024 - 64) ? 64 : 1024 - p;
    endfunction

    // Closed form of the divider pair after n ticks.
    function automatic int amp_of(input int n);
        int a, b;
        a = 6 + (n % 10);
        b = 5 + (n % 11);
        return ((a >= 8) ? 127 : 0) + ((b >= 8) ? 127 : 0);
    endfunction

    task automatic step(input logic r, input logic e, input logic s, input logic [7:0] lv);
        exp_t ex, got;
        rst = r;
        bus.engine_en = e;
        bus.clk_3MHz_en = s;
        bus.level = lv;
        if (r || !e) begin
            m_rem = 0;
            m_n = 0;
            ex.tick = 1'b0;
            ex.out = '0;
        end else begin
            ex.out = 8'(amp_of(m_n));
            ex.tick = 1'b0;
            if (s) begin
                if (m_rem == 0) begin
                    ex.tick = 1'b1;
                    m_n++;
                    m_rem = exp_period(int'(lv), 3) - 1;
                end else begin
                    m_rem--;
                end
                strobes++;
            end
        end
        sbq.push_back(ex);
        @(posedge clk);
        #1;
        got = sbq.pop_front();
        check("sb_tick", 16'(bus.vco_tick), 16'(got.tick));
        check("sb_out", 16'(bus.out), 16'(got.out));
    endtask

    task automatic wait_tick(input bit rnd, input logic [7:0] lv);
        logic s;
        bit seen;
        seen = 0;
        for (int i = 0; i < 3000 && !seen; i++) begin
            s = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
            step(1'b0, 1'b1, s, lv);
            if (bus.vco_tick === 1'b1) seen = 1;
        end
        if (!seen) check("tick_timeout", 16'd0, 16'd1);
    endtask

    task automatic run_strobes(input int n, input logic [7:0] lv);
        for (int i = 0; i < n; i++) step(1'b0, 1'b1, 1'b1, lv);
    endtask

    // Clamped instance: level 255 with SLOPE 4 must tick every 64 strobes.
    initial begin
        int t, t1, t2, t3, seen;
        bus4.engine_en = 1'b1;
        bus4.clk_3MHz_en = 1'b1;
        bus4.level = 8'd255;
        t = 0; seen = 0; t1 = 0; t2 = 0; t3 = 0;
        for (int i = 0; i < 400 && seen < 3; i++) begin
            @(posedge clk);
            #2;
            t++;
            if (bus4.vco_tick === 1'b1) begin
                seen++;
                if (seen == 1) t1 = t;
                if (seen == 2) t2 = t;
                if (seen == 3) t3 = t;
            end
        end
        check("clamp_ticks_seen", 16'(seen), 16'd3);
        check("clamp_period_1", 16'(t2 - t1), 16'd64);
        check("clamp_period_2", 16'(t3 - t2), 16'd64);
        dut4_done = 1;
    end

    initial begin
        bus.engine_en = 1'b0;
        bus.clk_3MHz_en = 1'b0;
        bus.level = '0;
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b1, 8'd0);
        check("rst_out", 16'(bus.out), 16'd0);
        check("rst_tick", 16'(bus.vco_tick), 16'd0);

        // Level 0: immediate first tick, then 1024-strobe periods.
        strobes = 0; wait_tick(0, 8'd0);
        check("first_tick_strobes", 16'(strobes), 16'd1);
        step(1'b0, 1'b1, 1'b0, 8'd0);
        check("out_t1", 16'(bus.out), 16'd0);
        strobes = 0; wait_tick(0, 8'd0);
        check("per_lvl0_a", 16'(strobes), 16'd1024);
        step(1'b0, 1'b1, 1'b0, 8'd0);
        check("out_t2", 16'(bus.out), 16'd127);
        strobes = 0; wait_tick(0, 8'd0);
        check("per_lvl0_b", 16'(strobes), 16'd1024);
        step(1'b0, 1'b1, 1'b0, 8'd0);
        check("out_t3", 16'(bus.out), 16'd254);

        // Mid-period level change only takes effect at the next reload.
        strobes = 0;
        run_strobes(500, 8'd0);
        wait_tick(0, 8'd100);
        check("per_mid_change", 16'(strobes), 16'd1024);
        strobes = 0; wait_tick(0, 8'd255);
        check("per_lvl100", 16'(strobes), 16'd724);

        // Level 255 with sparse strobes through the divider wrap points.
        for (int k = 6; k <= 14; k++) begin
            strobes = 0; wait_tick(1, 8'd255);
            check("per_lvl255", 16'(strobes), 16'd259);
            step(1'b0, 1'b1, 1'b0, 8'd255);
            if (k == 10) check("out_t10_a_wrap", 16'(bus.out), 16'd127);
            if (k == 11) check("out_t11_b_wrap", 16'(bus.out), 16'd0);
            if (k == 14) check("out_t14", 16'(bus.out), 16'd254);
        end

        // Disable mid-period with out at 254, then re-enable.
        run_strobes(100, 8'd255);
        step(1'b0, 1'b0, 1'b1, 8'd255);
        check("dis_out", 16'(bus.out), 16'd0);
        check("dis_tick", 16'(bus.vco_tick), 16'd0);
        for (int i = 0; i < 20; i++) step(1'b0, 1'b0, 1'b1, 8'd255);
        strobes = 0; wait_tick(0, 8'd255);
        check("reenable_first", 16'(strobes), 16'd1);

        // Reset on a tick boundary wins over enable and strobe.
        for (int i = 0; i < 400 && m_rem != 0; i++) step(1'b0, 1'b1, 1'b1, 8'd255);
        check("boundary_reached", 16'(m_rem), 16'd0);
        step(1'b1, 1'b1, 1'b1, 8'd255);
        check("rst_boundary_tick", 16'(bus.vco_tick), 16'd0);
        check("rst_boundary_out", 16'(bus.out), 16'd0);
        step(1'b0, 1'b1, 1'b1, 8'd255);
        check("post_rst_tick", 16'(bus.vco_tick), 16'd1);
        run_strobes(5, 8'd255);

        for (int i = 0; i < 100 && !dut4_done; i++) @(posedge clk);
        check("clamp_block_done", 16'(dut4_done), 16'd1);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/engine_vco.md
Name: engine_vco

Overview:
- Consumer end of the engine-sound LFO interface.
- Takes the 8-bit LFO level and converts it to a variable-rate tick. A higher level gives a shorter period, i.e. a higher pitch.
- The tick clocks two free-running 4-bit load-and-count dividers with different moduli.
- The two divider MSBs are mixed into an 8-bit unsigned engine waveform, which feeds the sound mixer.

Parameters:
- BASE_PERIOD, 1024: tick period in clk_3MHz_en strobes when level = 0.
- SLOPE, 3: period reduction per LFO level step.
- MIN_PERIOD, 64: lower clamp on tick period, in strobes.
- A_LOAD, 6: reload value of divider A. Counts 6..15, divide by 10.
- B_LOAD, 5: reload value of divider B. Counts 5..15, divide by 11.
- AMP, 127: output contribution of each divider MSB. AMP*2 must be ≤ 255.

Ports:
- clk  in  1  system clock
- rst  in  1  reset; synchronous, active-high; clock clk
- clk_3MHz_en  in  1  single-clk enable strobe at 3 MHz
- engine_en  in  1  engine sound enable; 0 silences and parks the block
- level  in  8  unsigned LFO level from the lfo block
- vco_tick  out  1  one-clk pulse per VCO period
- out  out  8  unsigned engine waveform

Behaviour:
- Reset values: cnt = 0, A = A_LOAD, B = B_LOAD, vco_tick = 0, out = 0. Reset mid-operation aborts everything at the next clk edge.
- Period computation (combinational, 16-bit unsigned):
  - prod = level*SLOPE.
  - If prod ≥ BASE_PERIOD − MIN_PERIOD: period = MIN_PERIOD.
  - Otherwise: period = BASE_PERIOD − prod.
  - No wrap-around allowed.
- Prescaler cnt (16-bit), advancing only on clocks with clk_3MHz_en = 1:
  - cnt == 0: cnt ← period − 1, and the tick condition fires.
  - Otherwise: cnt ← cnt − 1.
  - level is sampled only at reload. A level change takes effect at the next tick, never mid-period.
  - Ticks occur every `period` strobes. The first strobe after reset or after enabling ticks immediately.
- vco_tick: registered. It is 1 for exactly the clk after the strobe on which the tick condition fired, otherwise 0.
- Dividers, updated on the same edge as a tick:
  - A: if A == 15, A ← A_LOAD; otherwise A ← A + 1.
  - B: same rule with B_LOAD.
  - They never stall and never skip.
- out: registered every clk as out = AMP*A[3] + AMP*B[3]. Possible values are 0, AMP or 2*AMP. It reflects divider state with 1 clk latency.
- engine_en = 0, at each clk:
  - cnt ← 0, A ← A_LOAD, B ← B_LOAD, vco_tick ← 0, out ← 0.
  - Strobes are ignored.
  - On re-enable, behaviour is identical to post-reset.
- Simultaneous events:
  - rst has priority over engine_en, which has priority over clk_3MHz_en.
  - A level change on the same clk as a reload uses the new level.
- Strobe absent: all state holds, vco_tick = 0, and out keeps tracking the held A/B.

Test Plan:
- Reset → out = 0 and vco_tick = 0. Then engine_en = 1, level = 0, continuous strobes → first tick on strobe 1, then ticks every 1024 strobes.
- level = 255, SLOPE = 3 → prod = 765 < 960, so period = 259. Check ticks 259 strobes apart. Then set SLOPE = 4 (prod = 1020 ≥ 960) → period clamps to 64.
- Divider/output sequence from reset with engine_en = 1:
  - After tick 1: out = 0.
  - After tick 2: A = 8, out = 127.
  - After tick 3: B = 8, out = 254.
  - A wraps 15 → 6 on tick 10, leaving out = 127 (B still 15). B wraps 15 → 5 on tick 11, giving out = 0.
  - A has period 10 ticks with MSB high for 8; B has period 11 ticks with MSB high for 8.
- Change level from 0 to 100 mid-period → current period completes at 1024. The next period is 724.
- engine_en dropped mid-period with out = 254 → next clk out = 0, A = 6, B = 5, no ticks. Re-enable → tick on first strobe.
- rst asserted together with engine_en = 1 and a strobe on a tick boundary → all outputs at reset values, no tick emitted.
